rename: RTL and testbench
=========================

# rename

Register-rename stage between the decode→rename FIFO and the readreg stage. Each cycle it takes one group of up to `RENAME_WIDTH` decoded instructions. For each lane it claims free physical registers from the `rat` block, resolves source and old-destination mappings with intra-group bypass, and commits the new mappings to the `rat` (all-or-nothing). The renamed group is held in an output pipeline register with a stall/flush handshake toward readreg.

## Interface
- `RENAME_WIDTH`, 4, lanes per group (from config.svh)
- `PHY_REG_ID_WIDTH`, 6, physical register id width
- `ARCH_REG_ID_WIDTH`, 5, architectural register id width
- Clock/reset (already decided): one clock; reset is synchronous and active-high.
- `clk` in 1: clock
- `rst` in 1: synchronous active-high reset
- `decode_rename_valid` in RENAME_WIDTH: lane holds an instruction; lanes are packed from lane 0
- `decode_rename_rd`, `_rs1`, `_rs2` in ARCH_REG_ID_WIDTH ×RENAME_WIDTH: arch ids
- `decode_rename_rd_valid` in RENAME_WIDTH: lane writes rd
- `rename_decode_pop` out 1: group consumed this cycle
- `rat_rename_new_phy_id` in PHY_REG_ID_WIDTH ×RENAME_WIDTH, `rat_rename_new_phy_id_valid` in RENAME_WIDTH: free ids, packed
- `rename_rat_phy_id`, `rename_rat_phy_id_valid`, `rename_rat_arch_id`, `rename_rat_map` out: new mappings
- `rename_rat_read_arch_id` out ARCH ×RENAME_WIDTH×3: slot0 rs1, slot1 rs2, slot2 rd
- `rat_rename_read_phy_id` in PHY ×RENAME_WIDTH×3
- `readreg_rename_stall` in 1: downstream cannot accept
- `commit_feedback_flush` in 1: pipeline flush
- `rename_readreg_valid` out RENAME_WIDTH; `rename_readreg_rs1_phy`, `_rs2_phy`, `_rd_phy`, `_old_rd_phy` out PHY ×RENAME_WIDTH; `rename_readreg_rd_valid` out RENAME_WIDTH: registered group

## Operation
- Lane i needs allocation iff `valid[i] && rd_valid[i] && rd[i]!=0`. A write to x0 is treated as no destination.
- Lane i takes free id index k = popcount(need[0..i-1]). `need_cnt` = popcount(need).
- `accept` = any valid lane && `need_cnt` ≤ popcount(`rat_rename_new_phy_id_valid`) && (!out_valid_any || !stall) && !flush.
- On accept:
  - `rename_rat_map=1`, `rename_decode_pop=1`.
  - Per lane: `rename_rat_phy_id_valid[i]=need[i]`, `rename_rat_arch_id[i]=rd[i]`, `rename_rat_phy_id[i]=new id`.
  - Driven regardless of accept: the `rat` ignores them when map=0.
- Source bypass: rs1 of lane i equals rd of the highest lane j<i with `need[j]` → use lane j's new id. Otherwise use the RAT read result. rs==0 → phy 0.
- Old-rd bypass: the same rule applied to rd of lane i; the result goes to `old_rd_phy` (released at commit).
- No accept → no RAT update, no pop, and the input group is retried next cycle unchanged.

## Timing
- Reset: all `rename_readreg_*` outputs 0; `rename_rat_map`=0 and `rename_decode_pop`=0 (combinational, gated by rst).
- Latency: 1 cycle. The output register loads the accepted group on the edge after accept. RAT mapping becomes visible that same edge, so a back-to-back group reads updated mappings.
- Stall:
  - output valid && stall → output register holds and accept=0.
  - Output empty → accept is independent of stall.
- No accept while the output is free → output valid cleared on the next edge.
- Flush priority: flush > stall > accept. On flush the output valid clears next edge and map=0 and pop=0 this cycle.
- rst during a stall clears the output immediately on that edge.
- Insufficient free ids → whole group stalls; partial groups are never renamed.

## Structure
- Shared package/common.svh:
  - `rename_lane_t` struct: valid, rd_valid, rs1/rs2/rd/old_rd phy.
  - Width macros (already in config.svh).
- Sub-module `rename_bypass` (one per lane, combinational): given lane index, its rs/rd, the lower lanes' rd/need/new ids and the RAT read results, returns resolved phy ids.
- Top holds the allocation prefix counts, accept logic and output register.

## Test plan
- Reset then a single lane `rd=5`, `rs1=5`, free ids {40,41,42,43} → `rd_phy=40`, `rs1_phy`=RAT(5)=5, `old_rd_phy=5`, map=1; outputs valid next cycle.
- Four lanes all `rd=3`, lane k `rs1=3`, free {32,33,34,35} → rs1 = {3,32,33,34}, old_rd = {3,32,33,34}, rd = {32..35}.
- Lanes `rd` = {7,0,8,no-dest}, only 2 ids valid {50,51} → lane0 gets 50 and lane2 gets 51; lane1 (rd=x0) is not renamed; accepted.
- 3 lanes needing rd, only 2 free ids → no pop, map=0, output valid cleared; after ids are freed the group is accepted unchanged.
- Output valid + stall for 3 cycles → output stable, no pop; stall drops → next group loads next edge.
- Flush asserted with stall and a pending group → map=0, pop=0, output valid=0 next edge.

Source files
------------

// File: rtl/rename_pkg.sv
// Shared types, widths and helpers for the register-rename stage.
package rename_pkg;

  localparam int RENAME_WIDTH      = 4;
  localparam int PHY_REG_ID_WIDTH  = 6;
  localparam int ARCH_REG_ID_WIDTH = 5;
  localparam int CNT_WIDTH         = $clog2(RENAME_WIDTH + 1);
  localparam int IDX_WIDTH         = $clog2(RENAME_WIDTH);

  // Slot order of the per-lane RAT read ports.
  localparam int SLOT_RS1 = 0;
  localparam int SLOT_RS2 = 1;
  localparam int SLOT_RD  = 2;

  typedef logic [PHY_REG_ID_WIDTH-1:0]  phy_id_t;
  typedef logic [ARCH_REG_ID_WIDTH-1:0] arch_id_t;
  typedef logic [CNT_WIDTH-1:0]         cnt_t;
  typedef logic [IDX_WIDTH-1:0]         idx_t;
  typedef logic [RENAME_WIDTH-1:0]      lane_mask_t;

  typedef struct packed {
    logic    valid;
    logic    rd_valid;
    phy_id_t rs1_phy;
    phy_id_t rs2_phy;
    phy_id_t rd_phy;
    phy_id_t old_rd_phy;
  } rename_lane_t;

  function automatic cnt_t popcount(input lane_mask_t v);
    cnt_t c = '0;
    for (int i = 0; i < RENAME_WIDTH; i++) c = c + cnt_t'(v[i]);
    return c;
  endfunction

  // Highest writing lane in `need` whose rd matches wins; x0 always maps to phy 0.
  function automatic phy_id_t resolve(input arch_id_t a, input phy_id_t rat_val,
                                      input lane_mask_t need,
                                      input arch_id_t [RENAME_WIDTH-1:0] rd,
                                      input phy_id_t [RENAME_WIDTH-1:0] new_id);
    phy_id_t r = rat_val;
    for (int j = 0; j < RENAME_WIDTH; j++) begin
      if (need[j] && rd[j] == a) r = new_id[j];
    end
    return (a == '0) ? '0 : r;
  endfunction

endpackage

// File: rtl/rename_if.sv
// Decode, RAT and readreg signals of the rename stage; master is the rename side.
interface rename_if;
  import rename_pkg::*;

  lane_mask_t                     decode_rename_valid;
  lane_mask_t                     decode_rename_rd_valid;
  arch_id_t [RENAME_WIDTH-1:0]    decode_rename_rd;
  arch_id_t [RENAME_WIDTH-1:0]    decode_rename_rs1;
  arch_id_t [RENAME_WIDTH-1:0]    decode_rename_rs2;
  logic                           rename_decode_pop;

  phy_id_t  [RENAME_WIDTH-1:0]    rat_rename_new_phy_id;
  lane_mask_t                     rat_rename_new_phy_id_valid;
  phy_id_t  [RENAME_WIDTH-1:0]    rename_rat_phy_id;
  lane_mask_t                     rename_rat_phy_id_valid;
  arch_id_t [RENAME_WIDTH-1:0]    rename_rat_arch_id;
  logic                           rename_rat_map;
  arch_id_t [RENAME_WIDTH-1:0][2:0] rename_rat_read_arch_id;
  phy_id_t  [RENAME_WIDTH-1:0][2:0] rat_rename_read_phy_id;

  logic                           readreg_rename_stall;
  logic                           commit_feedback_flush;
  lane_mask_t                     rename_readreg_valid;
  lane_mask_t                     rename_readreg_rd_valid;
  phy_id_t  [RENAME_WIDTH-1:0]    rename_readreg_rs1_phy;
  phy_id_t  [RENAME_WIDTH-1:0]    rename_readreg_rs2_phy;
  phy_id_t  [RENAME_WIDTH-1:0]    rename_readreg_rd_phy;
  phy_id_t  [RENAME_WIDTH-1:0]    rename_readreg_old_rd_phy;

  modport master (
    input  decode_rename_valid, decode_rename_rd_valid, decode_rename_rd,
           decode_rename_rs1, decode_rename_rs2,
           rat_rename_new_phy_id, rat_rename_new_phy_id_valid, rat_rename_read_phy_id,
           readreg_rename_stall, commit_feedback_flush,
    output rename_decode_pop, rename_rat_phy_id, rename_rat_phy_id_valid,
           rename_rat_arch_id, rename_rat_map, rename_rat_read_arch_id,
           rename_readreg_valid, rename_readreg_rd_valid, rename_readreg_rs1_phy,
           rename_readreg_rs2_phy, rename_readreg_rd_phy, rename_readreg_old_rd_phy
  );

  modport slave (
    output decode_rename_valid, decode_rename_rd_valid, decode_rename_rd,
           decode_rename_rs1, decode_rename_rs2,
           rat_rename_new_phy_id, rat_rename_new_phy_id_valid, rat_rename_read_phy_id,
           readreg_rename_stall, commit_feedback_flush,
    input  rename_decode_pop, rename_rat_phy_id, rename_rat_phy_id_valid,
           rename_rat_arch_id, rename_rat_map, rename_rat_read_arch_id,
           rename_readreg_valid, rename_readreg_rd_valid, rename_readreg_rs1_phy,
           rename_readreg_rs2_phy, rename_readreg_rd_phy, rename_readreg_old_rd_phy
  );

endinterface

// File: rtl/rename_bypass.sv
// Per-lane source/old-destination resolution with bypass from lower lanes of the group.
module rename_bypass
  import rename_pkg::*;
#(
  parameter int LANE = 0
) (
  input  arch_id_t                    rs1,
  input  arch_id_t                    rs2,
  input  arch_id_t                    rd,
  input  arch_id_t [RENAME_WIDTH-1:0] lane_rd,
  input  lane_mask_t                  lane_need,
  input  phy_id_t  [RENAME_WIDTH-1:0] lane_new_id,
  input  phy_id_t  [2:0]              rat_phy,
  output phy_id_t                     rs1_phy,
  output phy_id_t                     rs2_phy,
  output phy_id_t                     old_rd_phy
);

  // Only lanes older than this one may forward a fresh mapping.
  localparam lane_mask_t LOWER = lane_mask_t'((1 << LANE) - 1);

  lane_mask_t lower_need;
  assign lower_need = lane_need & LOWER;

  assign rs1_phy    = resolve(rs1, rat_phy[SLOT_RS1], lower_need, lane_rd, lane_new_id);
  assign rs2_phy    = resolve(rs2, rat_phy[SLOT_RS2], lower_need, lane_rd, lane_new_id);
  assign old_rd_phy = resolve(rd,  rat_phy[SLOT_RD],  lower_need, lane_rd, lane_new_id);

endmodule

// File: rtl/rename.sv
// Rename stage: free-id allocation, all-or-nothing RAT commit and a stallable output register.
module rename
  import rename_pkg::*;
(
  input logic      clk,
  input logic      rst,
  rename_if.master bus
);

  lane_mask_t                  need;
  phy_id_t [RENAME_WIDTH-1:0]  new_id;
  phy_id_t [RENAME_WIDTH-1:0]  rs1_phy, rs2_phy, old_rd_phy;
  cnt_t                        need_cnt;
  cnt_t                        free_cnt;
  logic                        out_busy;
  logic                        accept;
  rename_lane_t [RENAME_WIDTH-1:0] lane_d, out_q;

  // Lane k takes the free id at index popcount(need[0..k-1]).
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    need     = bus.decode_rename_valid & bus.decode_rename_rd_valid;
    new_id   = '0;
    need_cnt = '0;
    for (int i = 0; i < RENAME_WIDTH; i++) begin
      if (bus.decode_rename_rd[i] == '0) need[i] = 1'b0;
      new_id[i] = bus.rat_rename_new_phy_id[idx_t'(need_cnt)];
      need_cnt  = need_cnt + cnt_t'(need[i]);
    end
  end

  assign free_cnt = popcount(bus.rat_rename_new_phy_id_valid);
  assign out_busy = |bus.rename_readreg_valid;
  assign accept   = !rst && !bus.commit_feedback_flush && (|bus.decode_rename_valid) &&
                    (need_cnt <= free_cnt) && !(out_busy && bus.readreg_rename_stall);

  assign bus.rename_decode_pop = accept;
  assign bus.rename_rat_map    = accept;

  always_comb begin
    bus.rename_rat_phy_id       = new_id;
    bus.rename_rat_phy_id_valid = need;
    bus.rename_rat_arch_id      = bus.decode_rename_rd;
    bus.rename_rat_read_arch_id = '0;
    for (int i = 0; i < RENAME_WIDTH; i++) begin
      bus.rename_rat_read_arch_id[i][SLOT_RS1] = bus.decode_rename_rs1[i];
      bus.rename_rat_read_arch_id[i][SLOT_RS2] = bus.decode_rename_rs2[i];
      bus.rename_rat_read_arch_id[i][SLOT_RD]  = bus.decode_rename_rd[i];
    end
  end

  for (genvar i = 0; i < RENAME_WIDTH; i++) begin : g_lane
    rename_bypass #(.LANE(i)) u_bypass (
      .rs1        (bus.decode_rename_rs1[i]),
      .rs2        (bus.decode_rename_rs2[i]),
      .rd         (bus.decode_rename_rd[i]),
      .lane_rd    (bus.decode_rename_rd),
      .lane_need  (need),
      .lane_new_id(new_id),
      .rat_phy    (bus.rat_rename_read_phy_id[i]),
      .rs1_phy    (rs1_phy[i]),
      .rs2_phy    (rs2_phy[i]),
      .old_rd_phy (old_rd_phy[i])
    );
  end

  // Empty lanes and lanes without a real destination carry zero ids.
  always_comb begin
    lane_d = '0;
    for (int i = 0; i < RENAME_WIDTH; i++) begin
      if (bus.decode_rename_valid[i]) begin
        lane_d[i].valid      = 1'b1;
        lane_d[i].rd_valid   = need[i];
        lane_d[i].rs1_phy    = rs1_phy[i];
        lane_d[i].rs2_phy    = rs2_phy[i];
        lane_d[i].rd_phy     = need[i] ? new_id[i] : '0;
        lane_d[i].old_rd_phy = need[i] ? old_rd_phy[i] : '0;
      end
    end
  end

  // Priority: reset, flush, stall-hold, then load or drain.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || bus.commit_feedback_flush) begin
      out_q <= '0;
    end else if (!(out_busy && bus.readreg_rename_stall)) begin
      out_q <= accept ? lane_d : '0;
    end
  end

  always_comb begin
    bus.rename_readreg_valid      = '0;
    bus.rename_readreg_rd_valid   = '0;
    bus.rename_readreg_rs1_phy    = '0;
    bus.rename_readreg_rs2_phy    = '0;
    bus.rename_readreg_rd_phy     = '0;
    bus.rename_readreg_old_rd_phy = '0;
    for (int i = 0; i < RENAME_WIDTH; i++) begin
      bus.rename_readreg_valid[i]      = out_q[i].valid;
      bus.rename_readreg_rd_valid[i]   = out_q[i].rd_valid;
      bus.rename_readreg_rs1_phy[i]    = out_q[i].rs1_phy;
      bus.rename_readreg_rs2_phy[i]    = out_q[i].rs2_phy;
      bus.rename_readreg_rd_phy[i]     = out_q[i].rd_phy;
      bus.rename_readreg_old_rd_phy[i] = out_q[i].old_rd_phy;
    end
  end

endmodule

// File: tb/tb_rename.sv
// Randomized and directed bench for rename against a sequential architectural-map model.
module tb_rename;
  import rename_pkg::*;

  localparam int W = RENAME_WIDTH;

  typedef struct packed {
    lane_mask_t        valid;
    lane_mask_t        rd_valid;
    arch_id_t [W-1:0]  rd;
    arch_id_t [W-1:0]  rs1;
    arch_id_t [W-1:0]  rs2;
  } grp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rename_if bus ();
  rename dut (.clk(clk), .rst(rst), .bus(bus));

  phy_id_t      rat_env [32];  // the RAT as the DUT sees it
  phy_id_t      ref_map [32];  // reference arch->phy map
  rename_lane_t exp_out [W];
  int total = 0;
  int bad   = 0;

  always_comb begin
    for (int i = 0; i < W; i++)
      for (int s = 0; s < 3; s++)
        bus.rat_rename_read_phy_id[i][s] = rat_env[bus.rename_rat_read_arch_id[i][s]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, check comb outputs, advance, check the register.
  task automatic cycle(input grp_t g, input phy_id_t [W-1:0] fid, input int nfree,
                       input logic stall, input logic flush, input logic rs);
    lane_mask_t   need;
    int           need_cnt, k;
    logic         busy, acc, cmd_map;
    rename_lane_t nxt [W];
    rename_lane_t obs;
    phy_id_t      tmp [32];
    phy_id_t  [W-1:0] cmd_phy;
    arch_id_t [W-1:0] cmd_arch;
    lane_mask_t   cmd_v;

    rst = rs;
    bus.decode_rename_valid    = g.valid;
    bus.decode_rename_rd_valid = g.rd_valid;
    bus.decode_rename_rd       = g.rd;
    bus.decode_rename_rs1      = g.rs1;
    bus.decode_rename_rs2      = g.rs2;
    bus.rat_rename_new_phy_id  = fid;
    for (int i = 0; i < W; i++) bus.rat_rename_new_phy_id_valid[i] = (i < nfree);
    bus.readreg_rename_stall  = stall;
    bus.commit_feedback_flush = flush;
    #1;

    need_cnt = 0;
    busy     = 1'b0;
    for (int i = 0; i < W; i++) begin
      need[i]  = g.valid[i] && g.rd_valid[i] && (g.rd[i] != '0);
      need_cnt += int'(need[i]);
      busy     |= exp_out[i].valid;
    end
    acc = (g.valid != '0) && (need_cnt <= nfree) && (!busy || !stall) && !flush && !rs;
    check("pop", 32'(bus.rename_decode_pop), 32'(acc));
    check("map", 32'(bus.rename_rat_map), 32'(acc));
    check("rat_v", 32'(bus.rename_rat_phy_id_valid), 32'(need));

    // Rename lane by lane against a scratch copy of the architectural map.
    tmp = ref_map;
    k   = 0;
    for (int i = 0; i < W; i++) begin
      nxt[i] = '0;
      if (g.valid[i]) begin
        nxt[i].valid   = 1'b1;
        nxt[i].rs1_phy = (g.rs1[i] == '0) ? '0 : tmp[g.rs1[i]];
        nxt[i].rs2_phy = (g.rs2[i] == '0) ? '0 : tmp[g.rs2[i]];
        if (need[i]) begin
          nxt[i].rd_valid   = 1'b1;
          nxt[i].old_rd_phy = tmp[g.rd[i]];
          nxt[i].rd_phy     = fid[k];
          tmp[g.rd[i]]      = fid[k];
          if (acc) check($sformatf("rat_cmd%0d", i),
                         32'({bus.rename_rat_arch_id[i], bus.rename_rat_phy_id[i]}),
                         32'({g.rd[i], fid[k]}));
          k++;
        end
      end
    end

    cmd_map  = bus.rename_rat_map;
    cmd_v    = bus.rename_rat_phy_id_valid;
    cmd_arch = bus.rename_rat_arch_id;
    cmd_phy  = bus.rename_rat_phy_id;

    @(posedge clk);
    #1;
    if (cmd_map)
      for (int i = 0; i < W; i++) if (cmd_v[i]) rat_env[cmd_arch[i]] = cmd_phy[i];

    if (rs || flush) begin
      for (int i = 0; i < W; i++) exp_out[i] = '0;
    end else if (!(busy && stall)) begin
      if (acc) begin
        for (int i = 0; i < W; i++) exp_out[i] = nxt[i];
        ref_map = tmp;
      end else begin
        for (int i = 0; i < W; i++) exp_out[i] = '0;
      end
    end

    for (int i = 0; i < W; i++) begin
      obs.valid      = bus.rename_readreg_valid[i];
      obs.rd_valid   = bus.rename_readreg_rd_valid[i];
      obs.rs1_phy    = bus.rename_readreg_rs1_phy[i];
      obs.rs2_phy    = bus.rename_readreg_rs2_phy[i];
      obs.rd_phy     = bus.rename_readreg_rd_phy[i];
      obs.old_rd_phy = bus.rename_readreg_old_rd_phy[i];
      check($sformatf("lane%0d", i), 32'(obs), 32'(exp_out[i]));
    end
    @(negedge clk);
  endtask

  grp_t            g, pend;
  phy_id_t [W-1:0] fid;

  initial begin
    for (int a = 0; a < 32; a++) begin
      rat_env[a] = phy_id_t'(a);
      ref_map[a] = phy_id_t'(a);
    end
    for (int i = 0; i < W; i++) exp_out[i] = '0;
    rst = 1'b1;
    @(negedge clk);

    // Reset with a valid group present: no pop/map, outputs zero.
    g = '0;
    g.valid[0] = 1'b1; g.rd_valid[0] = 1'b1; g.rd[0] = 5'd5; g.rs1[0] = 5'd5;
    for (int i = 0; i < W; i++) fid[i] = phy_id_t'(40 + i);
    cycle(g, fid, 4, 1'b0, 1'b0, 1'b1);
    cycle(g, fid, 4, 1'b0, 1'b0, 1'b1);
    check("rst_valid", 32'(bus.rename_readreg_valid), 32'd0);

    // Single lane rd=5 rs1=5.
    cycle(g, fid, 4, 1'b0, 1'b0, 1'b0);
    check("t1_rd", 32'(bus.rename_readreg_rd_phy[0]), 32'd40);
    check("t1_rs1", 32'(bus.rename_readreg_rs1_phy[0]), 32'd5);
    check("t1_old", 32'(bus.rename_readreg_old_rd_phy[0]), 32'd5);

    // Four lanes all writing x3 and reading x3: chained bypass.
    g = '0;
    for (int i = 0; i < W; i++) begin
      g.valid[i] = 1'b1; g.rd_valid[i] = 1'b1; g.rd[i] = 5'd3; g.rs1[i] = 5'd3;
      fid[i] = phy_id_t'(32 + i);
    end
    cycle(g, fid, 4, 1'b0, 1'b0, 1'b0);
    check("t2_rs1_l3", 32'(bus.rename_readreg_rs1_phy[3]), 32'd34);
    check("t2_old_l1", 32'(bus.rename_readreg_old_rd_phy[1]), 32'd32);
    check("t2_rd_l3", 32'(bus.rename_readreg_rd_phy[3]), 32'd35);

    // rd = {7, x0, 8, no-dest} with only two free ids.
    g = '0;
    g.valid = 4'b1111; g.rd_valid = 4'b0111;
    g.rd[0] = 5'd7; g.rd[1] = 5'd0; g.rd[2] = 5'd8; g.rd[3] = 5'd9;
    fid[0] = 6'd50; fid[1] = 6'd51; fid[2] = 6'd0; fid[3] = 6'd0;
    cycle(g, fid, 2, 1'b0, 1'b0, 1'b0);
    check("t3_rd_l2", 32'(bus.rename_readreg_rd_phy[2]), 32'd51);
    check("t3_rdv", 32'(bus.rename_readreg_rd_valid), 32'b0101);

    // Three destinations, two free ids: whole group waits, then goes unchanged.
    g = '0;
    g.valid = 4'b0111; g.rd_valid = 4'b0111;
    g.rd[0] = 5'd10; g.rd[1] = 5'd11; g.rd[2] = 5'd10; g.rs1[2] = 5'd10; g.rs2[1] = 5'd7;
    for (int i = 0; i < W; i++) fid[i] = phy_id_t'(20 + i);
    cycle(g, fid, 2, 1'b0, 1'b0, 1'b0);
    check("t4_cleared", 32'(bus.rename_readreg_valid), 32'd0);
    cycle(g, fid, 4, 1'b0, 1'b0, 1'b0);
    check("t4_rs1_l2", 32'(bus.rename_readreg_rs1_phy[2]), 32'd20);

    // Output held under a 3-cycle stall, then the pending group loads.
    pend = '0;
    pend.valid = 4'b0011; pend.rd_valid = 4'b0011;
    pend.rd[0] = 5'd12; pend.rd[1] = 5'd13; pend.rs1[1] = 5'd12;
    for (int i = 0; i < 3; i++) cycle(pend, fid, 4, 1'b1, 1'b0, 1'b0);
    check("t5_hold", 32'(bus.rename_readreg_valid), 32'b0111);
    cycle(pend, fid, 4, 1'b0, 1'b0, 1'b0);

    // Flush beats stall and a pending group.
    cycle(g, fid, 4, 1'b1, 1'b1, 1'b0);
    check("t6_flush", 32'(bus.rename_readreg_valid), 32'd0);

    // Random traffic over a small register window to exercise bypassing.
    for (int n = 0; n < 600; n++) begin
      int nv;
      nv = int'($urandom_range(0, W));
      g  = '0;
      for (int i = 0; i < W; i++) begin
        g.valid[i]    = (i < nv);
        g.rd_valid[i] = ($urandom_range(0, 3) != 0);
        g.rd[i]       = arch_id_t'($urandom_range(0, 7));
        g.rs1[i]      = arch_id_t'($urandom_range(0, 7));
        g.rs2[i]      = arch_id_t'($urandom_range(0, 31));
        fid[i]        = phy_id_t'($urandom_range(1, 63));
      end
      cycle(g, fid, int'($urandom_range(0, W)), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 49) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
